// File: rtl/neuron_mac_lanes_if.sv
// Handshake and operand bundle for one neuron: request side (vector in) and
// response side (activated result out).
interface neuron_mac_lanes_if #(
    parameter int N_INPUTS   = 8,
    parameter int DATA_WIDTH = 16
);
    logic                                 in_valid;
    logic                                 in_ready;
    logic [N_INPUTS-1:0][DATA_WIDTH-1:0]  a_in;
    logic [N_INPUTS-1:0][DATA_WIDTH-1:0]  w_in;
    logic signed [DATA_WIDTH-1:0]         bias;
    logic [1:0]                           act_mode;
    logic                                 out_valid;
    logic                                 out_ready;
    logic signed [DATA_WIDTH-1:0]         a_out;
    logic                                 sat_flag;

    modport master (
        output in_valid, a_in, w_in, bias, act_mode, out_ready,
        input  in_ready, out_valid, a_out, sat_flag
    );

    modport slave (
        input  in_valid, a_in, w_in, bias, act_mode, out_ready,
        output in_ready, out_valid, a_out, sat_flag
    );
endinterface

// File: rtl/neuron_mac_lanes.sv
// Multi-lane fixed-point neuron: LANES MACs per cycle over N_INPUTS operands,
// then bias add, Q rescale, activation and saturation to DATA_WIDTH.
module neuron_mac_lanes #(
    parameter int N_INPUTS   = 8,
    parameter int LANES      = 2,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    neuron_mac_lanes_if.slave bus
);
    localparam int IDX_W  = $clog2(N_INPUTS + LANES + 1);
    localparam int PROD_W = 2 * DATA_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    if (ACC_WIDTH < 2*DATA_WIDTH + $clog2(N_INPUTS) + 1) begin : g_acc_chk
        $error("neuron_mac_lanes: ACC_WIDTH too narrow for the dot product");
    end
    if (FRAC_BITS >= DATA_WIDTH) begin : g_frac_chk
        $error("neuron_mac_lanes: FRAC_BITS must be below DATA_WIDTH");
    end
    if (LANES < 1 || LANES > N_INPUTS) begin : g_lane_chk
        $error("neuron_mac_lanes: LANES must be in 1..N_INPUTS");
    end

    typedef enum logic [1:0] {IDLE, COMPUTE, FINISH, OUTPUT} state_t;

    state_t                              state_q, state_d;
    logic signed [ACC_WIDTH-1:0]         acc_q, acc_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [N_INPUTS-1:0][DATA_WIDTH-1:0] a_q, a_d, w_q, w_d;
    logic signed [DATA_WIDTH-1:0]        bias_q, bias_d;
    logic [1:0]                          mode_q, mode_d;
    logic signed [DATA_WIDTH-1:0]        a_out_q, a_out_d;
    logic                                sat_q, sat_d;

    logic signed [PROD_W-1:0]            prod [LANES];
    logic signed [ACC_WIDTH-1:0]         lane_sum, bias_acc, sum_s, scaled_r, act_r;
    logic [DATA_WIDTH:0]                 sat_res;
    logic [IDX_W-1:0]                    idx_next;

    function automatic logic signed [ACC_WIDTH-1:0] activate(
        input logic signed [ACC_WIDTH-1:0] r,
        input logic [1:0]                  mode
    );
        activate = r;
        if (r[ACC_WIDTH-1]) begin
            case (mode)
                2'd1:    activate = '0;
                2'd2:    activate = r >>> 3;
                default: activate = r;
            endcase
        end
    endfunction

    // Returns {clamped, value}.
    function automatic logic [DATA_WIDTH:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
        if (v > SAT_MAX)      saturate = {1'b1, SAT_MAX[DATA_WIDTH-1:0]};
        else if (v < SAT_MIN) saturate = {1'b1, SAT_MIN[DATA_WIDTH-1:0]};
        else                  saturate = {1'b0, v[DATA_WIDTH-1:0]};
    endfunction

    // Operand registers shift down by LANES each compute cycle, so the lanes
    // always read slots 0..LANES-1; zero fill makes padding lanes contribute 0.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign prod[g] = PROD_W'($signed(a_q[g])) * PROD_W'($signed(w_q[g]));
    end

    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum = lane_sum + ACC_WIDTH'(prod[k]);
        end
        bias_acc = ACC_WIDTH'(bias_q) <<< FRAC_BITS;
        sum_s    = acc_q + bias_acc;
        scaled_r = sum_s >>> FRAC_BITS;
        act_r    = activate(scaled_r, mode_q);
        sat_res  = saturate(act_r);
        idx_next = idx_q + IDX_W'(LANES);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        a_d     = a_q;
        w_d     = w_q;
        bias_d  = bias_q;
        mode_d  = mode_q;
        a_out_d = a_out_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a_in;
                    w_d     = bus.w_in;
                    bias_d  = bus.bias;
                    mode_d  = bus.act_mode;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                acc_d = acc_q + lane_sum;
                idx_d = idx_next;
                a_d   = a_q >> (LANES * DATA_WIDTH);
                w_d   = w_q >> (LANES * DATA_WIDTH);
                if (idx_next >= IDX_W'(N_INPUTS)) state_d = FINISH;
            end
            FINISH: begin
                a_out_d = sat_res[DATA_WIDTH-1:0];
                sat_d   = sat_res[DATA_WIDTH];
                state_d = OUTPUT;
            end
            OUTPUT: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            a_q     <= '0;
            w_q     <= '0;
            bias_q  <= '0;
            mode_q  <= '0;
            a_out_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            w_q     <= w_d;
            bias_q  <= bias_d;
            mode_q  <= mode_d;
            a_out_q <= a_out_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == OUTPUT);
    assign bus.a_out     = a_out_q;
    assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_neuron_mac_lanes.sv
// Directed bench for neuron_mac_lanes: an N=8/L=2 instance for the main
// function, backpressure and reset abort, plus an N=5/L=2 instance for padding.
module tb_neuron_mac_lanes;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    neuron_mac_lanes_if #(.N_INPUTS(8), .DATA_WIDTH(16)) if8 ();
    neuron_mac_lanes_if #(.N_INPUTS(5), .DATA_WIDTH(16)) if5 ();

    neuron_mac_lanes #(.N_INPUTS(8), .LANES(2), .DATA_WIDTH(16), .FRAC_BITS(8), .ACC_WIDTH(48))
        u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    neuron_mac_lanes #(.N_INPUTS(5), .LANES(2), .DATA_WIDTH(16), .FRAC_BITS(8), .ACC_WIDTH(48))
        u_dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive8(input int aval, input int wval, input int b, input int mode);
        for (int i = 0; i < 8; i++) begin
            if8.a_in[i] = 16'(aval);
            if8.w_in[i] = 16'(wval);
        end
        if8.bias     = 16'(b);
        if8.act_mode = 2'(mode);
    endtask

    // Accept one vector on the N=8 instance, scramble inputs afterwards, and
    // check latency, result and (optionally) the output handshake.
    task automatic run8(input string tag, input int aval, input int wval, input int b,
                        input int mode, input int exp_out, input int exp_sat,
                        input bit release_out);
        int lat;
        @(negedge clk);
        drive8(aval, wval, b, mode);
        if8.in_valid = 1'b1;
        check_eq({tag, "_in_ready"}, if8.in_ready, 1);
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        drive8(-1, 12345, -7, ~mode);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!if8.out_valid && lat < 20);
        check_eq({tag, "_latency"}, lat, 5);
        check_eq({tag, "_a_out"}, if8.a_out, exp_out);
        check_eq({tag, "_sat"}, if8.sat_flag, exp_sat);
        if (release_out) begin
            @(negedge clk);
            if8.out_ready = 1'b1;
            @(posedge clk);
            #1;
            if8.out_ready = 1'b0;
            check_eq({tag, "_valid_drop"}, if8.out_valid, 0);
            check_eq({tag, "_ready_back"}, if8.in_ready, 1);
            check_eq({tag, "_a_out_held"}, if8.a_out, exp_out);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  stable;
        if8.in_valid = 1'b0; if8.out_ready = 1'b0;
        if5.in_valid = 1'b0; if5.out_ready = 1'b0;
        drive8(0, 0, 0, 0);
        if5.a_in = '0; if5.w_in = '0; if5.bias = '0; if5.act_mode = 2'd0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", if8.in_ready, 1);
        check_eq("rst_out_valid", if8.out_valid, 0);
        check_eq("rst_a_out", if8.a_out, 0);
        check_eq("rst_sat", if8.sat_flag, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run8("pos_m0", 256, 128, 64, 0, 1088, 0, 1);
        run8("neg_m0", 256, -128, 64, 0, -960, 0, 1);
        run8("neg_relu", 256, -128, 64, 1, 0, 0, 1);
        run8("neg_leaky", 256, -128, 64, 2, -120, 0, 1);
        run8("neg_m3", 256, -128, 64, 3, -960, 0, 1);
        run8("floor_m0", 1, -1, 0, 0, -1, 0, 1);
        run8("floor_leaky", 1, -1, 0, 2, -1, 0, 1);

        // Backpressure: result held while in_valid is pulsed with other operands.
        run8("bp", 256, 128, 64, 0, 1088, 0, 0);
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drive8(100, 100, 100, 1);
            if8.in_valid = (c % 2 == 0);
            @(posedge clk);
            #1;
            if (!(if8.out_valid === 1'b1 && if8.a_out === 16'sd1088 &&
                  if8.sat_flag === 1'b0 && if8.in_ready === 1'b0)) stable = 1'b0;
        end
        @(negedge clk);
        if8.in_valid = 1'b0;
        check_eq("bp_stable", stable, 1);
        if8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if8.out_ready = 1'b0;
        check_eq("bp_valid_drop", if8.out_valid, 0);
        check_eq("bp_ready_back", if8.in_ready, 1);
        check_eq("bp_a_out_kept", if8.a_out, 1088);

        run8("sat_pos", 32767, 32767, 0, 0, 32767, 1, 1);
        run8("sat_neg", -32768, 32767, 0, 0, -32768, 1, 1);

        // Abort two cycles into COMPUTE; sat_flag and a_out were nonzero.
        @(negedge clk);
        drive8(256, 128, 64, 0);
        if8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_in_ready", if8.in_ready, 1);
        check_eq("abort_out_valid", if8.out_valid, 0);
        check_eq("abort_a_out", if8.a_out, 0);
        check_eq("abort_sat", if8.sat_flag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run8("post_abort", 512, 256, -256, 0, 3840, 0, 1);

        // N=5, L=2: three compute cycles, one padding lane on the last.
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if5.a_in[i] = 16'(256 * (i + 1));
            if5.w_in[i] = 16'(256);
        end
        if5.bias = '0;
        if5.act_mode = 2'd0;
        if5.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if5.in_valid = 1'b0;
        if5.a_in = '1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!if5.out_valid && lat < 20);
        check_eq("n5_latency", lat, 4);
        check_eq("n5_a_out", if5.a_out, 3840);
        check_eq("n5_sat", if5.sat_flag, 0);
        @(negedge clk);
        if5.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if5.out_ready = 1'b0;
        check_eq("n5_valid_drop", if5.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
